// File: rtl/spi_pkg.sv
// Shared constants and state encoding for the SPI move-link responder.
package spi_pkg;

    localparam int unsigned FRAME_BITS  = 8;
    localparam int unsigned CNT_W       = 4;
    localparam int unsigned MOVE_MSB    = 7;
    localparam int unsigned MOVE_LSB    = 3;
    localparam int unsigned CONFIRM_BIT = 2;
    localparam int unsigned FPGA_BIT    = 1;
    localparam int unsigned INFO_BIT    = 0;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        HOLD  = 2'd2
    } spi_slv_state_t;

endpackage

// File: rtl/spi_sync_edge.sv
// Multi-flop synchronizer for one asynchronous input, with one-cycle rise/fall pulses.
module spi_sync_edge #(
    parameter int unsigned SYNC_STAGES = 2,
    parameter logic        RESET_VAL   = 1'b0
) (
    input  logic clk,
    input  logic rst,
    input  logic din,
    output logic level,
    output logic rise_c,
    output logic fall_c
);

    logic [SYNC_STAGES-1:0] sync_q;
    logic                   prev_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sync_q <= {SYNC_STAGES{RESET_VAL}};
            prev_q <= RESET_VAL;
        end else begin
            sync_q <= {sync_q[SYNC_STAGES-2:0], din};
            prev_q <= sync_q[SYNC_STAGES-1];
        end
    end

    assign level  = sync_q[SYNC_STAGES-1];
    assign rise_c = level & ~prev_q;
    assign fall_c = ~level & prev_q;

endmodule

// File: rtl/spi_slave_rx.sv
// SPI mode-0 responder: receives one MSB-first byte per frame, decodes the move
// fields, and shifts a queued reply byte out on miso.
module spi_slave_rx
    import spi_pkg::*;
#(
    parameter int unsigned SYNC_STAGES = 2,
    parameter logic [7:0]  IDLE_BYTE   = 8'h00
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       sclk,
    input  logic       ss,
    input  logic       mosi,
    output logic       miso,
    input  logic [7:0] tx_data,
    input  logic       tx_valid,
    output logic       tx_ready,
    output logic [7:0] rx_data,
    output logic       rx_valid,
    output logic [4:0] move_index,
    output logic       confirm,
    output logic       from_fpga,
    output logic       info_ready,
    output logic       frame_err,
    output logic       busy
);

    logic sclk_s, sclk_rise, sclk_fall;
    logic ss_s, ss_rise, ss_fall;
    logic mosi_s, mosi_rise_unused, mosi_fall_unused;
    logic sclk_s_unused, ss_s_unused;

    spi_sync_edge #(.SYNC_STAGES(SYNC_STAGES), .RESET_VAL(1'b0)) u_sync_sclk (
        .clk(clk), .rst(rst), .din(sclk),
        .level(sclk_s), .rise_c(sclk_rise), .fall_c(sclk_fall)
    );

    // ss idles high, so its synchronizer resets high to avoid a false frame start.
    spi_sync_edge #(.SYNC_STAGES(SYNC_STAGES), .RESET_VAL(1'b1)) u_sync_ss (
        .clk(clk), .rst(rst), .din(ss),
        .level(ss_s), .rise_c(ss_rise), .fall_c(ss_fall)
    );

    spi_sync_edge #(.SYNC_STAGES(SYNC_STAGES), .RESET_VAL(1'b0)) u_sync_mosi (
        .clk(clk), .rst(rst), .din(mosi),
        .level(mosi_s), .rise_c(mosi_rise_unused), .fall_c(mosi_fall_unused)
    );

    assign sclk_s_unused = sclk_s;
    assign ss_s_unused   = ss_s;

    spi_slv_state_t              state_q, state_d;
    logic [CNT_W-1:0]            bit_cnt_q, bit_cnt_d;
    logic [FRAME_BITS-2:0]       rx_shift_q, rx_shift_d;
    logic [FRAME_BITS-2:0]       tx_shift_q, tx_shift_d;
    logic [FRAME_BITS-1:0]       tx_buf_q, tx_buf_d;
    logic [FRAME_BITS-1:0]       rx_data_d;
    logic [FRAME_BITS-1:0]       load_c;
    logic                        pending_q, pending_d;
    logic                        miso_d, rx_valid_d, frame_err_d;
    logic                        capture_c;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= IDLE;
            bit_cnt_q  <= '0;
            rx_shift_q <= '0;
            tx_shift_q <= '0;
            tx_buf_q   <= '0;
            pending_q  <= 1'b0;
            miso       <= 1'b0;
            rx_data    <= '0;
            rx_valid   <= 1'b0;
            frame_err  <= 1'b0;
            busy       <= 1'b0;
            tx_ready   <= 1'b1;
        end else begin
            state_q    <= state_d;
            bit_cnt_q  <= bit_cnt_d;
            rx_shift_q <= rx_shift_d;
            tx_shift_q <= tx_shift_d;
            tx_buf_q   <= tx_buf_d;
            pending_q  <= pending_d;
            miso       <= miso_d;
            rx_data    <= rx_data_d;
            rx_valid   <= rx_valid_d;
            frame_err  <= frame_err_d;
            busy       <= (state_d != IDLE);
            tx_ready   <= ~pending_d;
        end
    end

    assign capture_c = tx_valid & ~pending_q;
    // A reply offered in the same cycle as the frame start goes straight to the shifter.
    assign load_c    = pending_q ? tx_buf_q : (capture_c ? tx_data : IDLE_BYTE);

    always_comb begin
        state_d     = state_q;
        bit_cnt_d   = bit_cnt_q;
        rx_shift_d  = rx_shift_q;
        tx_shift_d  = tx_shift_q;
        tx_buf_d    = tx_buf_q;
        pending_d   = pending_q;
        miso_d      = miso;
        rx_data_d   = rx_data;
        rx_valid_d  = 1'b0;
        frame_err_d = 1'b0;

        if (capture_c) begin
            tx_buf_d  = tx_data;
            pending_d = 1'b1;
        end

        unique case (state_q)
            IDLE: begin
                miso_d = 1'b0;
                if (ss_fall) begin
                    tx_shift_d = load_c[FRAME_BITS-2:0];
                    miso_d     = load_c[FRAME_BITS-1];
                    pending_d  = 1'b0;
                    bit_cnt_d  = '0;
                    rx_shift_d = '0;
                    state_d    = SHIFT;
                end
            end
            SHIFT: begin
                // ss_rise takes priority over a coincident sclk_rise.
                if (ss_rise) begin
                    frame_err_d = 1'b1;
                    miso_d      = 1'b0;
                    state_d     = IDLE;
                end else if (sclk_rise) begin
                    rx_shift_d = {rx_shift_q[FRAME_BITS-3:0], mosi_s};
                    bit_cnt_d  = bit_cnt_q + CNT_W'(1);
                    if (bit_cnt_q == CNT_W'(FRAME_BITS - 1)) begin
                        rx_data_d  = {rx_shift_q, mosi_s};
                        rx_valid_d = 1'b1;
                        state_d    = HOLD;
                    end
                end else if (sclk_fall && (bit_cnt_q != '0) &&
                             (bit_cnt_q < CNT_W'(FRAME_BITS))) begin
                    miso_d     = tx_shift_q[FRAME_BITS-2];
                    tx_shift_d = {tx_shift_q[FRAME_BITS-3:0], 1'b0};
                end
            end
            HOLD: begin
                if (ss_rise) begin
                    miso_d  = 1'b0;
                    state_d = IDLE;
                end
            end
            default: begin
                miso_d  = 1'b0;
                state_d = IDLE;
            end
        endcase
    end

    assign move_index = rx_data[MOVE_MSB:MOVE_LSB];
    assign confirm    = rx_data[CONFIRM_BIT];
    assign from_fpga  = rx_data[FPGA_BIT];
    assign info_ready = rx_data[INFO_BIT];

endmodule

// File: tb/tb_spi_slave_rx.sv
// Bench for spi_slave_rx: bit-banged SPI master, table vectors, hand sequences and random frames.
module tb_spi_slave_rx;

    localparam int unsigned SYNC   = 2;
    localparam int unsigned HALF   = SYNC + 4;
    localparam logic [7:0]  IDLE_B = 8'h00;

    logic       clk, rst, sclk, ss, mosi, miso;
    logic [7:0] tx_data;
    logic       tx_valid, tx_ready;
    logic [7:0] rx_data;
    logic       rx_valid;
    logic [4:0] move_index;
    logic       confirm, from_fpga, info_ready, frame_err, busy;

    spi_slave_rx #(.SYNC_STAGES(SYNC), .IDLE_BYTE(IDLE_B)) dut (
        .clk(clk), .rst(rst), .sclk(sclk), .ss(ss), .mosi(mosi), .miso(miso),
        .tx_data(tx_data), .tx_valid(tx_valid), .tx_ready(tx_ready),
        .rx_data(rx_data), .rx_valid(rx_valid), .move_index(move_index),
        .confirm(confirm), .from_fpga(from_fpga), .info_ready(info_ready),
        .frame_err(frame_err), .busy(busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_chk  = 0;
    int n_pass = 0;
    int rxv_cnt = 0;
    int ferr_cnt = 0;
    logic [7:0] exp_rx;

    always @(negedge clk) begin
        if (rx_valid) rxv_cnt = rxv_cnt + 1;
        if (frame_err) ferr_cnt = ferr_cnt + 1;
    end

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_chk = n_chk + 1;
        if (act === exp) n_pass = n_pass + 1;
        else $display("FAIL %s: got 0x%0h expected 0x%0h", nm, act, exp);
    endtask

    task automatic wait_cyc(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic queue_reply(input string nm, input logic [7:0] v);
        tx_data  = v;
        tx_valid = 1'b1;
        wait_cyc(1);
        tx_valid = 1'b0;
        chk({nm, "_tx_ready_full"}, 32'(tx_ready), 32'd0);
    endtask

    task automatic sclk_pulse(input logic b, input bit sample, output logic m);
        mosi = b;
        wait_cyc(HALF);
        m = sample ? miso : 1'b0;
        sclk = 1'b1;
        wait_cyc(HALF);
        sclk = 1'b0;
    endtask

    task automatic run_frame(input string nm, input logic [7:0] b, input int pulses,
                             input bit bypass, input logic [7:0] byp, output logic [7:0] rd);
        logic m;
        rd = '0;
        ss = 1'b0;
        if (bypass) begin
            // offer the reply exactly in the cycle the slave sees ss fall
            wait_cyc(SYNC);
            tx_data  = byp;
            tx_valid = 1'b1;
            wait_cyc(1);
            tx_valid = 1'b0;
            chk({nm, "_bypass_tx_ready"}, 32'(tx_ready), 32'd1);
            wait_cyc(HALF - SYNC - 1);
        end else begin
            wait_cyc(HALF);
        end
        for (int i = 0; i < pulses; i++) begin
            sclk_pulse((i < 8) ? b[7-i] : 1'b0, i < 8, m);
            if (i < 8) rd[7-i] = m;
        end
        wait_cyc(HALF);
        ss = 1'b1;
        wait_cyc(2 * HALF);
    endtask

    task automatic apply(input string nm, input logic [7:0] b, input int pulses,
                         input bit has_reply, input logic [7:0] reply, input bit bypass,
                         input logic [7:0] e_rx, input logic [7:0] e_miso);
        int rv0, fe0;
        logic [7:0] rd;
        if (has_reply && !bypass) queue_reply(nm, reply);
        rv0 = rxv_cnt;
        fe0 = ferr_cnt;
        run_frame(nm, b, pulses, bypass, reply, rd);
        chk({nm, "_miso_byte"}, 32'(rd), 32'(e_miso));
        chk({nm, "_rx_valid_cnt"}, 32'(rxv_cnt - rv0), (pulses >= 8) ? 32'd1 : 32'd0);
        chk({nm, "_frame_err_cnt"}, 32'(ferr_cnt - fe0), (pulses >= 8) ? 32'd0 : 32'd1);
        chk({nm, "_rx_data"}, 32'(rx_data), 32'(e_rx));
        chk({nm, "_move_index"}, 32'(move_index), 32'(e_rx) / 32'd8);
        chk({nm, "_flags"}, {29'd0, confirm, from_fpga, info_ready}, 32'(e_rx) % 32'd8);
        chk({nm, "_tx_ready_idle"}, 32'(tx_ready), 32'd1);
        chk({nm, "_busy_idle"}, 32'(busy), 32'd0);
    endtask

    typedef struct {
        logic [7:0] b;
        int         pulses;
        bit         has_reply;
        logic [7:0] reply;
        bit         bypass;
        logic [7:0] e_rx;
        logic [7:0] e_miso;
    } vec_t;

    vec_t tbl[6];

    initial begin
        logic m;
        logic [7:0] b, reply, mask, e_miso;
        int pulses, n;
        bit has, byp;

        tbl[0] = '{8'h9F, 8,  1'b0, 8'h00, 1'b0, 8'h9F, 8'h00};
        tbl[1] = '{8'h3C, 8,  1'b1, 8'hA5, 1'b0, 8'h3C, 8'hA5};
        tbl[2] = '{8'h55, 5,  1'b0, 8'h00, 1'b0, 8'h3C, 8'h00};
        tbl[3] = '{8'hC3, 8,  1'b0, 8'h00, 1'b0, 8'hC3, 8'h00};
        tbl[4] = '{8'h81, 10, 1'b0, 8'h00, 1'b0, 8'h81, 8'h00};
        tbl[5] = '{8'h12, 8,  1'b1, 8'h5A, 1'b1, 8'h12, 8'h5A};

        rst = 1'b1; ss = 1'b1; sclk = 1'b0; mosi = 1'b0;
        tx_data = '0; tx_valid = 1'b0;
        wait_cyc(3);
        chk("reset_outputs", {miso, rx_valid, frame_err, busy, tx_ready, rx_data},
            {27'd0, 5'b00001, 8'h00} >> 0);
        rst = 1'b0;
        wait_cyc(2 * HALF);
        chk("post_reset_idle", {29'd0, busy, miso, tx_ready}, 32'd1);

        foreach (tbl[i])
            apply($sformatf("vec%0d", i), tbl[i].b, tbl[i].pulses, tbl[i].has_reply,
                  tbl[i].reply, tbl[i].bypass, tbl[i].e_rx, tbl[i].e_miso);

        // reset in the middle of a frame, with a reply queued after the frame start
        ss = 1'b0;
        wait_cyc(HALF);
        for (int i = 0; i < 3; i++) sclk_pulse(1'b1, 1'b0, m);
        chk("mid_frame_busy", 32'(busy), 32'd1);
        queue_reply("mid_frame", 8'hEE);
        rst = 1'b1;
        wait_cyc(1);
        chk("rst_mid_outputs", {miso, rx_valid, frame_err, busy, tx_ready, rx_data},
            {27'd0, 5'b00001, 8'h00} >> 0);
        chk("rst_mid_fields", {24'd0, move_index, confirm, from_fpga, info_ready}, 32'd0);
        ss = 1'b1;
        wait_cyc(SYNC + 2);
        rst = 1'b0;
        wait_cyc(2 * HALF);
        exp_rx = 8'h00;
        apply("after_rst", 8'h07, 8, 1'b0, 8'h00, 1'b0, 8'h07, IDLE_B);
        exp_rx = 8'h07;

        for (int k = 0; k < 20; k++) begin
            b      = 8'($urandom);
            reply  = 8'($urandom);
            pulses = int'($urandom_range(3, 10));
            has    = 1'($urandom_range(0, 1));
            byp    = has && ($urandom_range(0, 3) == 0);
            n      = (pulses < 8) ? pulses : 8;
            mask   = '0;
            for (int j = 0; j < n; j++) mask[7-j] = 1'b1;
            e_miso = (has ? reply : IDLE_B) & mask;
            if (pulses >= 8) exp_rx = b;
            apply($sformatf("rnd%0d", k), b, pulses, has, reply, byp, exp_rx, e_miso);
        end

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL timeout: got no finish expected finish");
        $fatal(1);
    end

endmodule

// File: doc/spi_slave_rx.md
# spi_slave_rx

SPI mode-0 responder (slave) for the 8-bit game-move link, MSB first. It synchronizes externally driven `sclk`/`ss`/`mosi` into `clk`, shifts in one byte per frame, and decodes the move-byte fields. In parallel it shifts a queued reply byte out on `miso`. It sits on the peer side of the move link, so FPGA-to-FPGA and loopback benches can run against the existing master.

## Interface
Parameters:
- `SYNC_STAGES`, 2 — flip-flop stages on each async SPI input (≥2)
- `IDLE_BYTE`, 8'h00 — reply byte sent when no reply is queued

Ports:
- `clk`  in  1  system clock
- `rst`  in  1  reset, asynchronous, active-high
- `sclk`  in  1  SPI clock from master, idle low
- `ss`  in  1  slave select, active low
- `mosi`  in  1  master out, slave in
- `miso`  out  1  master in, slave out
- `tx_data`  in  8  reply byte for the next frame
- `tx_valid`  in  1  `tx_data` offered
- `tx_ready`  out  1  reply buffer empty; `tx_valid && tx_ready` captures
- `rx_data`  out  8  last complete received byte
- `rx_valid`  out  1  one-cycle pulse: `rx_data` and fields updated
- `move_index`  out  5  `rx_data[7:3]`
- `confirm`  out  1  `rx_data[2]`
- `from_fpga`  out  1  `rx_data[1]`
- `info_ready`  out  1  `rx_data[0]`
- `frame_err`  out  1  one-cycle pulse: `ss` rose before 8 bits
- `busy`  out  1  frame in progress (state ≠ IDLE)

## Operation
- Inputs pass through `SYNC_STAGES` flops. Edge detection compares the last sync stage with one extra registered copy, giving `sclk_rise`, `sclk_fall`, `ss_fall`, `ss_rise` (one-cycle pulses).
- States:
  - **IDLE**
    - `ss_fall` → load `tx_shift` and drive `miso` = `tx_shift[7]`; `bit_cnt` = 0; go to SHIFT.
    - `tx_shift` source at load: `tx_buf` if pending, else `IDLE_BYTE`. The pending flag clears on load.
  - **SHIFT**
    - `sclk_rise` → `rx_shift` = {`rx_shift[6:0]`, `mosi_s`}; `bit_cnt`++.
    - `sclk_fall` with 1 ≤ `bit_cnt` ≤ 7 → `tx_shift` <<= 1; `miso` = new `tx_shift[7]`.
    - 8th `sclk_rise` → go to HOLD and register `rx_data` in the same edge.
    - `ss_rise` → `frame_err` pulse; partial byte discarded; `rx_data` unchanged; go to IDLE.
  - **HOLD**
    - Extra `sclk` edges ignored; `miso` holds its last bit.
    - `ss_rise` → go to IDLE, no error.
- Field outputs are combinational slices of registered `rx_data`.
- `miso` = 0 in IDLE.
- Reply buffer:
  - `tx_ready` = !pending.
  - `tx_valid && tx_ready` → `tx_buf` = `tx_data`; pending = 1.
  - If capture and `ss_fall` coincide with pending = 0, `tx_data` bypasses straight into `tx_shift` and pending stays 0.
- `sclk_rise` and `ss_rise` in the same cycle: `ss_rise` wins; the bit is not counted.
- `rst` mid-frame: every register returns to its reset value immediately; the next `ss_fall` starts a clean frame.

## Timing
- Reset values:
  - `miso`, `rx_data`, `rx_valid`, `frame_err`, `busy` all 0, so field outputs are 0.
  - `tx_ready` = 1; state is IDLE.
- Input-to-edge-pulse latency is `SYNC_STAGES`+1 clk cycles.
- `rx_valid` asserts the clk cycle after the cycle in which the 8th `sclk_rise` is detected, high for exactly 1 cycle.
- `miso` changes one cycle after the detected `ss_fall`/`sclk_fall`.
- Master requirement: `sclk` high and low phases each ≥ `SYNC_STAGES`+3 clk cycles, and `ss` low ≥ the same before the first `sclk` rise.
- `bit_cnt` is 4 bits; it never wraps within a frame.

## Structure
- Package `spi_pkg`:
  - `FRAME_BITS` = 8
  - field position constants (`MOVE_MSB` = 7, `MOVE_LSB` = 3, `CONFIRM_BIT` = 2, `FPGA_BIT` = 1, `INFO_BIT` = 0)
  - state enum `spi_slv_state_t` {IDLE, SHIFT, HOLD}
- Sub-module `spi_sync_edge`:
  - parameterized synchronizer plus rise/fall pulse generator
  - instantiated three times (`sclk`, `ss`, `mosi`; `mosi` uses the level output only)

## Test plan
- Master sends 0x9F (move 19, all flag bits set) with no reply queued → one `rx_valid`; `rx_data` = 0x9F; `move_index` = 19; `confirm` = `from_fpga` = `info_ready` = 1; master reads 0x00 on `miso`.
- Queue 0xA5 (`tx_valid` while `tx_ready`), then run a frame sending 0x3C → master reads 0xA5; `rx_data` = 0x3C; `tx_ready` returns to 1 at `ss_fall`.
- `ss` rises after 5 bits → `frame_err` pulse; no `rx_valid`; `rx_data` keeps its prior value; the next full frame is received correctly.
- 10 `sclk` pulses in one frame sending 0x81 → `rx_data` = 0x81 after pulse 8; pulses 9–10 ignored; a single `rx_valid`.
- `tx_valid` coincides with `ss_fall` while the buffer is empty, `tx_data` = 0x5A → master reads 0x5A.
- Assert `rst` after bit 3 → all outputs at reset values; the following frame 0x07 yields `move_index` = 0 and `rx_data` = 0x07.
